// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller: access-size encodings,
// FSM state enum and the wait-state bound.
package dmem_pkg;

  // Access size encodings (2'b11 is handled like a word access)
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  // Largest supported WAIT_CYC and the counter width that covers it
  localparam int WAIT_CYC_MAX = 15;
  localparam int CNT_W        = $clog2(WAIT_CYC_MAX + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_ram.sv
// DEPTH x 32-bit storage with per-byte-lane write enables and an
// asynchronous read port sharing the single address.
module dmem_ram #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        be,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [31:0] mem [DEPTH];

  // Lane-masked write; contents are intentionally never reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_ctrl.sv
// Single-outstanding data-memory controller: IDLE -> WAIT (WAIT_CYC cycles)
// -> RESP. Store commit and load sample both happen on the edge entering RESP.
// Handshake: a request transfers on a rising edge where req_valid && req_ready;
// a response transfers on a rising edge where rsp_valid && rsp_ready, and the
// response fields stay stable while rsp_valid is high and rsp_ready is low.
// Optional macro DMEM_MISALIGN_ERR_EN: misaligned accesses fault (rsp_err=1,
// no store, rdata 0) instead of having their low address bits forced to zero.
// The FSM state is kept in the named signal 'state' for checker binding.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int WAIT_CYC = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam logic [CNT_W-1:0] WAIT_LAST =
    (WAIT_CYC > 0) ? CNT_W'(WAIT_CYC - 1) : '0;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic             enter_resp;

  // Latched request (only the address bits that select a word and lane)
  logic              q_we, q_uns;
  logic [1:0]        q_size;
  logic [ADDR_W+1:0] q_addr;
  logic [31:0]       q_wdata;

  // Effective request: live inputs while accepting, latched fields afterwards
  logic              eff_we, eff_uns;
  logic [1:0]        eff_size;
  logic [ADDR_W+1:0] eff_addr;
  logic [31:0]       eff_wdata;

  logic [1:0]  off;
  logic        err;
  logic [3:0]  be, ram_be;
  logic [31:0] wlanes, ram_rdata, shifted, load_ext;
  logic        err_q;

  // Address bits above the word index wrap around
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

  // State register and wait counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Next-state logic; enter_resp marks the commit/sample edge
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    enter_resp   = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          wait_cnt_nxt = '0;
          if (WAIT_CYC == 0) begin
            state_nxt  = RESP;
            enter_resp = 1'b1;
          end else begin
            state_nxt  = WAIT;
          end
        end
      end
      WAIT: begin
        if (wait_cnt == WAIT_LAST) begin
          state_nxt  = RESP;
          enter_resp = 1'b1;
        end else begin
          wait_cnt_nxt = wait_cnt + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);

  // Capture the whole request on acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_we    <= 1'b0;
      q_uns   <= 1'b0;
      q_size  <= 2'b00;
      q_addr  <= '0;
      q_wdata <= '0;
    end else if (state == IDLE && req_valid) begin
      q_we    <= req_we;
      q_uns   <= req_unsigned;
      q_size  <= req_size;
      q_addr  <= req_addr[ADDR_W+1:0];
      q_wdata <= req_wdata;
    end
  end

  // With WAIT_CYC=0 the commit edge is the accept edge, so use live inputs
  always_comb begin
    if (state == IDLE) begin
      eff_we    = req_we;
      eff_uns   = req_unsigned;
      eff_size  = req_size;
      eff_addr  = req_addr[ADDR_W+1:0];
      eff_wdata = req_wdata;
    end else begin
      eff_we    = q_we;
      eff_uns   = q_uns;
      eff_size  = q_size;
      eff_addr  = q_addr;
      eff_wdata = q_wdata;
    end
  end

  // Alignment policy: fault on misalignment, or force offending bits to zero
  always_comb begin
`ifdef DMEM_MISALIGN_ERR_EN
    off = eff_addr[1:0];
    err = (eff_size == SZ_H && eff_addr[0]) ||
          (eff_size == SZ_W && eff_addr[1:0] != 2'b00) ||
          (eff_size == 2'b11);
`else
    err = 1'b0;
    case (eff_size)
      SZ_B:    off = eff_addr[1:0];
      SZ_H:    off = {eff_addr[1], 1'b0};
      default: off = 2'b00;
    endcase
`endif
  end

  // Store lane enables and replicated write data
  always_comb begin
    case (eff_size)
      SZ_B: begin
        be     = 4'b0001 << off;
        wlanes = {4{eff_wdata[7:0]}};
      end
      SZ_H: begin
        be     = 4'b0011 << off;
        wlanes = {2{eff_wdata[15:0]}};
      end
      default: begin
        be     = 4'b1111;
        wlanes = eff_wdata;
      end
    endcase
    ram_be = (enter_resp && eff_we && !err && rst_n) ? be : 4'b0000;
  end

  dmem_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .addr  (eff_addr[ADDR_W+1:2]),
    .be    (ram_be),
    .wdata (wlanes),
    .rdata (ram_rdata)
  );

  // Right-align the addressed lanes and extend
  always_comb begin
    shifted = ram_rdata >> {off, 3'b000};
    case (eff_size)
      SZ_B:    load_ext = eff_uns ? {24'h0, shifted[7:0]}
                                  : {{24{shifted[7]}}, shifted[7:0]};
      SZ_H:    load_ext = eff_uns ? {16'h0, shifted[15:0]}
                                  : {{16{shifted[15]}}, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  // Response registers load on the edge entering RESP and hold until consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_rdata <= '0;
      err_q     <= 1'b0;
    end else if (enter_resp) begin
      rsp_rdata <= (eff_we || err) ? 32'h0 : load_ext;
      err_q     <= err;
    end
  end

  assign rsp_err = err_q;

endmodule
